// File: rtl/mem_slot_arbiter.sv
// Slot-based arbiter granting one of NPORTS requesters access to a shared memory
// per ena-delimited slot; fixed-priority or round-robin with per-port burst lock.
module mem_slot_arbiter #(
  parameter int NPORTS = 3,
  parameter int AW     = 25,
  parameter int DW     = 8,
  parameter int RR     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS-1:0]    lock,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] din,
  output logic [NPORTS-1:0]    ack,
  output logic [DW-1:0]        rdata,
  output logic [NPORTS-1:0]    rvalid,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_din,
  output logic                 mem_wr,
  output logic                 mem_rd,
  input  logic [DW-1:0]        mem_dout,
  output logic [NPORTS-1:0]    grant,
  output logic                 busy
);

  localparam int IW = $clog2(NPORTS);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]        state;
  logic [IW-1:0]     owner_idx;
  logic [IW-1:0]     last_owner;
  logic [IW-1:0]     win_idx;
  logic              win_any;
  logic [NPORTS-1:0] cand;
  logic [NPORTS-1:0] win_oh;
  logic [AW-1:0]     addr_a [NPORTS];
  logic [DW-1:0]     din_a  [NPORTS];

  for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
    assign addr_a[g] = addr[g*AW +: AW];
    assign din_a[g]  = din[g*DW +: DW];
  end

  // The finishing owner is excluded from the next slot unless it holds lock,
  // since its req is still high in the very cycle its ack is produced.
  always_comb begin
    int p;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cand    = req;
    win_idx = '0;
    win_any = 1'b0;
    win_oh  = '0;
    p       = 0;
    if (state == ACTIVE) begin
      cand = (lock[owner_idx] && req[owner_idx]) ? grant : (req & ~grant);
    end
    if (RR == 0) begin
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (cand[IW'(i)]) begin
          win_idx = IW'(i);
          win_any = 1'b1;
        end
      end
    end else begin
      // Walk downward so the port nearest after last_owner is assigned last.
      for (int k = NPORTS; k >= 1; k--) begin
        p = int'(last_owner) + k;
        if (p >= NPORTS) p = p - NPORTS;
        if (cand[IW'(p)]) begin
          win_idx = IW'(p);
          win_any = 1'b1;
        end
      end
    end
    win_oh[win_idx] = win_any;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner_idx  <= '0;
      last_owner <= IW'(NPORTS - 1);
      grant      <= '0;
      ack        <= '0;
      rvalid     <= '0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      ack    <= '0;
      rvalid <= '0;
      if (ena) begin
        if (state == ACTIVE) begin
          ack <= grant;
          if (mem_rd) begin
            rdata  <= mem_dout;
            rvalid <= grant;
          end
        end
        if (win_any) begin
          state      <= ACTIVE;
          grant      <= win_oh;
          owner_idx  <= win_idx;
          last_owner <= win_idx;
          mem_addr   <= addr_a[win_idx];
          mem_din    <= din_a[win_idx];
          mem_wr     <= we[win_idx];
          mem_rd     <= ~we[win_idx];
          busy       <= 1'b1;
        end else begin
          state    <= IDLE;
          grant    <= '0;
          mem_addr <= '0;
          mem_din  <= '0;
          mem_wr   <= 1'b0;
          mem_rd   <= 1'b0;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Self-checking bench: a fixed-priority and a round-robin instance, each compared
// every cycle against a slot-level reference model, plus directed boundary cases.
module tb_mem_slot_arbiter;

  localparam int NP = 3;
  localparam int AW = 25;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ena;
  logic [DW-1:0] mem_dout;

  logic [NP-1:0]    req_d  [2];
  logic [NP-1:0]    we_d   [2];
  logic [NP-1:0]    lock_d [2];
  logic [NP*AW-1:0] addr_d [2];
  logic [NP*DW-1:0] din_d  [2];

  logic [NP-1:0] ack_o    [2];
  logic [NP-1:0] rvalid_o [2];
  logic [NP-1:0] grant_o  [2];
  logic [DW-1:0] rdata_o  [2];
  logic [DW-1:0] mdin_o   [2];
  logic [AW-1:0] maddr_o  [2];
  logic          wr_o     [2];
  logic          rd_o     [2];
  logic          busy_o   [2];

  always #5 clk = ~clk;

  // Instance 0 is fixed priority, instance 1 is round-robin.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_slot_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .RR(g)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .ena      (ena),
      .req      (req_d[g]),
      .we       (we_d[g]),
      .lock     (lock_d[g]),
      .addr     (addr_d[g]),
      .din      (din_d[g]),
      .ack      (ack_o[g]),
      .rdata    (rdata_o[g]),
      .rvalid   (rvalid_o[g]),
      .mem_addr (maddr_o[g]),
      .mem_din  (mdin_o[g]),
      .mem_wr   (wr_o[g]),
      .mem_rd   (rd_o[g]),
      .mem_dout (mem_dout),
      .grant    (grant_o[g]),
      .busy     (busy_o[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the slot, what it latched, what the outputs should be.
  int            m_owner [2];
  int            m_last  [2];
  logic          m_we    [2];
  logic [NP-1:0] e_grant [2];
  logic [NP-1:0] e_ack   [2];
  logic [NP-1:0] e_rvalid[2];
  logic          e_busy  [2];
  logic          e_wr    [2];
  logic          e_rd    [2];
  logic [DW-1:0] e_rdata [2];
  logic [AW-1:0] e_addr  [2];
  logic [DW-1:0] e_din   [2];

  bit rnd    = 0;
  int p_req  = 0;
  int p_lock = 0;
  int p_drop = 0;

  task automatic model_reset(input int m);
    m_owner[m]  = -1;
    m_last[m]   = NP - 1;
    m_we[m]     = 1'b0;
    e_grant[m]  = '0;
    e_ack[m]    = '0;
    e_rvalid[m] = '0;
    e_busy[m]   = 1'b0;
    e_wr[m]     = 1'b0;
    e_rd[m]     = 1'b0;
    e_rdata[m]  = '0;
    e_addr[m]   = '0;
    e_din[m]    = '0;
  endtask

  function automatic int pick(input int m);
    int p;
    for (int k = 0; k < NP; k++) begin
      p = (m == 0) ? k : (m_last[m] + 1 + k) % NP;
      if (req_d[m][p] && p != m_owner[m]) return p;
    end
    return -1;
  endfunction

  task automatic model_edge(input int m);
    int nxt;
    int o;
    e_ack[m]    = '0;
    e_rvalid[m] = '0;
    if (!ena) return;
    nxt = -1;
    o   = m_owner[m];
    if (o >= 0) begin
      e_ack[m] = NP'(1) << o;
      if (!m_we[m]) begin
        e_rdata[m]  = mem_dout;
        e_rvalid[m] = NP'(1) << o;
      end
      if (lock_d[m][o] && req_d[m][o]) nxt = o;
    end
    if (nxt < 0) nxt = pick(m);
    m_owner[m] = nxt;
    if (nxt >= 0) begin
      m_last[m]  = nxt;
      m_we[m]    = we_d[m][nxt];
      e_grant[m] = NP'(1) << nxt;
      e_busy[m]  = 1'b1;
      e_wr[m]    = we_d[m][nxt];
      e_rd[m]    = !we_d[m][nxt];
      e_addr[m]  = addr_d[m][nxt*AW +: AW];
      e_din[m]   = din_d[m][nxt*DW +: DW];
    end else begin
      e_grant[m] = '0;
      e_busy[m]  = 1'b0;
      e_wr[m]    = 1'b0;
      e_rd[m]    = 1'b0;
    end
  endtask

  task automatic compare(input int m);
    check($sformatf("m%0d ctl{grant,ack,rvalid,busy,wr,rd}", m),
          {grant_o[m], ack_o[m], rvalid_o[m], busy_o[m], wr_o[m], rd_o[m]},
          {e_grant[m], e_ack[m], e_rvalid[m], e_busy[m], e_wr[m], e_rd[m]});
    check($sformatf("m%0d rdata", m), rdata_o[m], e_rdata[m]);
    if (e_busy[m]) begin
      check($sformatf("m%0d mem_addr", m), maddr_o[m], e_addr[m]);
      check($sformatf("m%0d mem_din", m), mdin_o[m], e_din[m]);
    end
  endtask

  task automatic set_req(input int m, input int p, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_d[m][p]          = 1'b1;
    we_d[m][p]           = w;
    addr_d[m][p*AW +: AW] = a;
    din_d[m][p*DW +: DW]  = d;
  endtask

  // Requesters hold req until ack; a lock re-grant keeps the access in flight.
  task automatic requesters(input int m);
    for (int p = 0; p < NP; p++) begin
      if (e_ack[m][p] && m_owner[m] != p) req_d[m][p] = 1'b0;
      if (rnd) begin
        if (m_owner[m] == p && req_d[m][p] && !e_ack[m][p] && $urandom_range(99) < p_drop)
          req_d[m][p] = 1'b0;
        lock_d[m][p] = ($urandom_range(99) < p_lock);
      end
      if (!req_d[m][p] && m_owner[m] != p && $urandom_range(99) < p_req)
        set_req(m, p, 1'($urandom), AW'($urandom), DW'($urandom));
    end
  endtask

  task automatic step(input logic en, input int dout = -1, input bit glitch = 0);
    if (glitch) begin
      #1 ena = 1'b1;
      #2 ena = 1'b0;
    end
    ena      = en;
    mem_dout = (dout < 0) ? DW'($urandom) : DW'(dout);
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
    requesters(0);
    requesters(1);
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    ena      = 1'b0;
    mem_dout = '0;
    for (int m = 0; m < 2; m++) begin
      req_d[m]  = '0;
      we_d[m]   = '0;
      lock_d[m] = '0;
      addr_d[m] = '0;
      din_d[m]  = '0;
      model_reset(m);
    end
    repeat (2) @(negedge clk);
    check("reset grant", {grant_o[0], grant_o[1]}, 0);
    check("reset busy/wr/rd", {busy_o[0], wr_o[0], rd_o[0], busy_o[1], wr_o[1], rd_o[1]}, 0);
    check("reset mem_addr", {maddr_o[0], maddr_o[1]}, 0);
    compare(0);
    compare(1);
    reset = 1'b0;
    step(0);
    step(0);

    // Fixed priority: req=110 -> port 1, then port 2.
    for (int m = 0; m < 2; m++) begin
      set_req(m, 1, 1'b1, 25'h00123, 8'h11);
      set_req(m, 2, 1'b1, 25'h00456, 8'h22);
    end
    step(1);
    check("fp first grant", grant_o[0], 3'b010);
    step(0);
    step(0);
    step(1);
    check("fp ack port1", ack_o[0], 3'b010);
    check("fp second grant", grant_o[0], 3'b100);
    step(0);
    step(0);
    step(1);
    check("fp ack port2", ack_o[0], 3'b100);
    check("fp idle after drain", {grant_o[0], busy_o[0]}, 0);

    // Read on port 0 with mem_dout=A5 at slot end.
    set_req(0, 0, 1'b0, 25'h15608, 8'h00);
    step(1);
    check("read mem_addr", maddr_o[0], 25'h15608);
    check("read mem_rd/wr", {rd_o[0], wr_o[0]}, 2'b10);
    step(0);
    step(0);
    step(1, 8'hA5);
    check("read rdata", rdata_o[0], 8'hA5);
    check("read rvalid/ack", {rvalid_o[0], ack_o[0]}, 6'b001_001);
    step(0);
    check("rdata held", rdata_o[0], 8'hA5);

    // Round-robin with all ports requesting continuously.
    p_req = 100;
    step(0);
    for (int s = 0; s < 4; s++) begin
      step(1);
      check($sformatf("rr grant slot %0d", s), grant_o[1], 3'b001 << (s % 3));
      step(0);
    end
    p_req = 0;
    repeat (8) step(1);

    // Lock: port 2 owns and locks while port 0 waits.
    set_req(0, 2, 1'b1, 25'h1ABCD, 8'h5A);
    step(1);
    set_req(0, 0, 1'b1, 25'h00001, 8'h01);
    lock_d[0][2] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step(0);
      step(1);
      check($sformatf("lock hold slot %0d", s), {grant_o[0], ack_o[0]}, 6'b100_100);
    end
    lock_d[0][2] = 1'b0;
    step(0);
    step(1);
    check("lock released", {grant_o[0], ack_o[0]}, 6'b001_100);
    step(0);
    step(1);
    check("after lock drain", {grant_o[0], ack_o[0]}, 6'b000_001);

    // Idle for ten slots.
    for (int s = 0; s < 10; s++) begin
      step(1);
      check($sformatf("idle slot %0d", s),
            {grant_o[0], busy_o[0], wr_o[0], rd_o[0], grant_o[1], busy_o[1], wr_o[1], rd_o[1]}, 0);
    end

    // A sub-cycle ena glitch is not a slot boundary.
    set_req(0, 1, 1'b1, 25'h0F0F0, 8'h33);
    set_req(1, 1, 1'b1, 25'h0F0F1, 8'h44);
    step(0, -1, 1);
    check("glitch no grant", {grant_o[0], grant_o[1]}, 0);
    step(1);
    check("grant after real ena", grant_o[0], 3'b010);

    // Reset in mid-slot: everything drops at once, no ack, restart from port 0.
    for (int m = 0; m < 2; m++) begin
      set_req(m, 0, 1'b1, 25'h00AAA, 8'h55);
      set_req(m, 2, 1'b1, 25'h00BBB, 8'h66);
    end
    step(0);
    #2 reset = 1'b1;
    #1;
    check("async reset grant", {grant_o[0], grant_o[1]}, 0);
    check("async reset busy/wr", {busy_o[0], wr_o[0], busy_o[1], wr_o[1]}, 0);
    model_reset(0);
    model_reset(1);
    ena = 1'b1;
    @(posedge clk);
    #1;
    check("no ack under reset", {ack_o[0], ack_o[1]}, 0);
    compare(0);
    compare(1);
    @(negedge clk);
    reset = 1'b0;
    ena   = 1'b0;
    step(1);
    check("post-reset grant", {grant_o[0], grant_o[1]}, 6'b001_001);
    repeat (6) step(1);

    // Randomized traffic against the model.
    rnd    = 1;
    p_req  = 30;
    p_lock = 15;
    p_drop = 5;
    repeat (3000) step($urandom_range(99) < 35);
    rnd   = 0;
    p_req = 0;
    for (int m = 0; m < 2; m++) lock_d[m] = '0;
    repeat (10) step(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
